// File: rtl/canny_stage_sequencer_if.sv
// canny_stage_sequencer_if
//   Control bundle between the Canny frame sequencer and its host/pipeline.
//   Signals:
//     start_en      host -> seq  frame start request (sampled only while idle)
//     stall         host -> seq  freeze slot counter, mask stage enables
//     abort         host -> seq  terminate the running frame
//     pop_buffer_en seq -> pipe  buffer block pop
//     shift_en      seq -> pipe  shifter advance
//     hold_en       seq -> pipe  hold block capture
//     mult_en       seq -> pipe  multiplier start
//     mag_dir_en    seq -> pipe  magnitude/direction start
//     out_en        seq -> pipe  output block enable
//     get_next      seq -> pipe  next-frame SRAM prefetch request
//     busy          seq -> host  high while a frame is running
//     frame_done    seq -> host  one-cycle pulse at frame end or abort
//     slot_cnt      seq -> host  current slot count
//     state_dbg     seq -> host  raw FSM state for observation
//
//   Handshake: start_en is a level request taken on the first rising edge at
//   which the sequencer is idle; busy acknowledges it on the following cycle
//   and stays high for the whole frame. frame_done is a single-cycle pulse
//   that always coincides with busy falling; a new start_en is only honoured
//   from the cycle after that pulse.
interface canny_stage_sequencer_if #(
  parameter int CNT_W = 24
);
  logic             start_en;
  logic             stall;
  logic             abort;
  logic             pop_buffer_en;
  logic             shift_en;
  logic             hold_en;
  logic             mult_en;
  logic             mag_dir_en;
  logic             out_en;
  logic             get_next;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output start_en, stall, abort,
    input  pop_buffer_en, shift_en, hold_en, mult_en, mag_dir_en, out_en,
           get_next, busy, frame_done, slot_cnt, state_dbg
  );

  modport slave (
    input  start_en, stall, abort,
    output pop_buffer_en, shift_en, hold_en, mult_en, mag_dir_en, out_en,
           get_next, busy, frame_done, slot_cnt, state_dbg
  );
endinterface

// File: rtl/canny_stage_sequencer.sv
// canny_stage_sequencer
//   Frame sequencer for the Canny pipeline. Counts pixel-word slots across a
//   frame (optionally skipping every other line) and raises each stage enable
//   one cycle after the slot counter sits inside that stage's window.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    canny_stage_sequencer_if.slave (start/stall/abort in; stage
//            enables, get_next, busy, frame_done, slot_cnt, state_dbg out)
module canny_stage_sequencer #(
  parameter int CNT_W      = 24,
  parameter int LINE_BITS  = 8,
  parameter int SKIP_ALT   = 1,
  parameter int T_POP      = 2,
  parameter int T_SHIFT_A  = 4,
  parameter int T_SHIFT_B  = 13,
  parameter int T_MULT     = 14,
  parameter int T_MAGDIR   = 15,
  parameter int T_OUT      = 18,
  parameter int T_PREFETCH = 2200575,
  parameter int T_END      = 2621400
) (
  input logic clk,
  input logic reset,
  canny_stage_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic pop;
    logic shift;
    logic hold;
    logic mult;
    logic magDir;
    logic out;
    logic getNext;
  } stageEn_t;

  // Arithmetic is done one bit wider than the counter so the carry out of the
  // increment is visible and ends the frame instead of silently wrapping.
  localparam logic [CNT_W:0] ONE_STEP  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] SKIP_STEP = (CNT_W+1)'((1 << LINE_BITS) + 1);
  localparam logic [CNT_W:0] END_X     = (CNT_W+1)'(T_END);

  state_t           state;
  logic [CNT_W-1:0] slotCnt;
  logic             busyReg;
  logic             frameDoneReg;
  stageEn_t         enReg;

  logic [CNT_W:0]   cntX;
  logic             lineEnd;
  logic [CNT_W:0]   step;
  logic [CNT_W:0]   nextSum;
  logic             frameEnd;
  stageEn_t         enHit;

  // Half-open window test [lo, lo+len) on the widened count.
  function automatic logic inWin(input logic [CNT_W:0] c, input int lo, input int len);
    return (c >= (CNT_W+1)'(lo)) && (c < (CNT_W+1)'(lo + len));
  endfunction

  always_comb begin
    cntX     = {1'b0, slotCnt};
    lineEnd  = &slotCnt[LINE_BITS-1:0];
    // At a line end the jump of 2^LINE_BITS+1 lands on the first slot of the
    // line after next, so every other line is skipped.
    step     = ((SKIP_ALT != 0) && lineEnd) ? SKIP_STEP : ONE_STEP;
    nextSum  = cntX + step;
    frameEnd = nextSum[CNT_W] || (nextSum >= END_X);

    enHit         = '0;
    enHit.pop     = inWin(cntX, T_POP, 2);
    enHit.shift   = inWin(cntX, T_SHIFT_A, 2) || inWin(cntX, T_SHIFT_B, 1);
    enHit.hold    = inWin(cntX, T_SHIFT_B, 1);
    enHit.mult    = inWin(cntX, T_MULT, 2);
    enHit.magDir  = inWin(cntX, T_MAGDIR, 2);
    enHit.out     = inWin(cntX, T_OUT, 4);
    enHit.getNext = inWin(cntX, T_PREFETCH, 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      slotCnt      <= '0;
      busyReg      <= 1'b0;
      frameDoneReg <= 1'b0;
      enReg        <= '0;
    end else begin
      // Enables and frame_done are pulses; only the RUN advance path sets them.
      enReg        <= '0;
      frameDoneReg <= 1'b0;
      case (state)
        IDLE: begin
          busyReg <= 1'b0;
          if (bus.start_en) begin
            state   <= RUN;
            slotCnt <= '0;
            busyReg <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            // Abort takes priority over stall.
            state        <= DONE;
            slotCnt      <= '0;
            busyReg      <= 1'b0;
            frameDoneReg <= 1'b1;
          end else if (bus.stall) begin
            // Counter frozen; enables stay cleared by the default above.
            slotCnt <= slotCnt;
          end else if (frameEnd) begin
            state        <= DONE;
            slotCnt      <= '0;
            busyReg      <= 1'b0;
            frameDoneReg <= 1'b1;
          end else begin
            slotCnt <= nextSum[CNT_W-1:0];
            enReg   <= enHit;
          end
        end
        DONE: begin
          // start_en is deliberately not looked at here.
          state   <= IDLE;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop_buffer_en = enReg.pop;
  assign bus.shift_en      = enReg.shift;
  assign bus.hold_en       = enReg.hold;
  assign bus.mult_en       = enReg.mult;
  assign bus.mag_dir_en    = enReg.magDir;
  assign bus.out_en        = enReg.out;
  assign bus.get_next      = enReg.getNext;
  assign bus.busy          = busyReg;
  assign bus.frame_done    = frameDoneReg;
  assign bus.slot_cnt      = slotCnt;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_canny_stage_sequencer.sv
module tb_canny_stage_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  canny_stage_sequencer_if #(.CNT_W(24)) bus_def ();
  canny_stage_sequencer_if #(.CNT_W(24)) bus_ns ();
  canny_stage_sequencer_if #(.CNT_W(24)) bus_sm ();

  // Default parameters.
  canny_stage_sequencer u_def (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_def)
  );

  // No line skip.
  canny_stage_sequencer #(.SKIP_ALT(0)) u_ns (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ns)
  );

  // Short frame: 16-slot lines, ends at 40, prefetch at 33, pop at 15.
  canny_stage_sequencer #(
    .LINE_BITS  (4),
    .T_END      (40),
    .T_PREFETCH (33),
    .T_POP      (15)
  ) u_sm (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sm)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  // Advance one clock; observations are taken 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pop, shift, hold, mult, mag_dir, out, get_next}
  function automatic logic [6:0] en_def();
    return {bus_def.pop_buffer_en, bus_def.shift_en, bus_def.hold_en, bus_def.mult_en,
            bus_def.mag_dir_en, bus_def.out_en, bus_def.get_next};
  endfunction

  function automatic logic [6:0] en_sm();
    return {bus_sm.pop_buffer_en, bus_sm.shift_en, bus_sm.hold_en, bus_sm.mult_en,
            bus_sm.mag_dir_en, bus_sm.out_en, bus_sm.get_next};
  endfunction

  // Hand table of the default windows: enables seen in the cycle after count c.
  function automatic logic [6:0] exp_def(input int c);
    return {(c == 2 || c == 3),
            (c == 4 || c == 5 || c == 13),
            (c == 13),
            (c == 14 || c == 15),
            (c == 15 || c == 16),
            (c >= 18 && c <= 21),
            1'b0};
  endfunction

  // Short-frame slot sequence per RUN cycle: 0..15, then 32..39, then 0 in DONE.
  function automatic int exp_sm_slot(input int k);
    if (k <= 15) return k;
    if (k <= 23) return k + 16;
    return 0;
  endfunction

  int pop_cnt;
  int mult_cnt;
  int gn_cnt;

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_def.start_en = 1'b0; bus_def.stall = 1'b0; bus_def.abort = 1'b0;
    bus_ns.start_en  = 1'b0; bus_ns.stall  = 1'b0; bus_ns.abort  = 1'b0;
    bus_sm.start_en  = 1'b0; bus_sm.stall  = 1'b0; bus_sm.abort  = 1'b0;

    // Reset must dominate a simultaneous start request.
    reset = 1'b1;
    bus_def.start_en = 1'b1;
    bus_sm.start_en  = 1'b1;
    bus_ns.start_en  = 1'b1;
    repeat (3) tick();
    check("rst_busy",   32'(bus_def.busy), 0);
    check("rst_slot",   32'(bus_def.slot_cnt), 0);
    check("rst_en",     32'(en_def()), 0);
    check("rst_done",   32'(bus_def.frame_done), 0);
    check("rst_sm_en",  32'(en_sm()), 0);
    check("rst_sm_busy", 32'(bus_sm.busy), 0);
    reset = 1'b0;
    bus_def.start_en = 1'b0;
    bus_sm.start_en  = 1'b0;
    bus_ns.start_en  = 1'b0;
    tick();
    check("idle_busy", 32'(bus_def.busy), 0);

    // ---- default frame: windows, stall at 14 ----
    bus_def.start_en = 1'b1;
    tick();
    bus_def.start_en = 1'b0;
    check("start_busy", 32'(bus_def.busy), 1);
    pop_cnt  = 0;
    mult_cnt = 0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      check("win_slot", 32'(bus_def.slot_cnt), 32'(k));
      check("win_en",   32'(en_def()), 32'(exp_def(k - 1)));
      pop_cnt  += int'(bus_def.pop_buffer_en);
      mult_cnt += int'(bus_def.mult_en);
    end
    bus_def.stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("stall_slot", 32'(bus_def.slot_cnt), 14);
      check("stall_en",   32'(en_def()), 0);
    end
    bus_def.stall = 1'b0;
    for (int k = 15; k <= 24; k++) begin
      tick();
      check("win_slot", 32'(bus_def.slot_cnt), 32'(k));
      check("win_en",   32'(en_def()), 32'(exp_def(k - 1)));
      pop_cnt  += int'(bus_def.pop_buffer_en);
      mult_cnt += int'(bus_def.mult_en);
    end
    check("pop_cycles",  32'(pop_cnt), 2);
    check("mult_cycles", 32'(mult_cnt), 2);

    // ---- line skip 255 -> 512 ----
    for (int k = 25; k <= 255; k++) tick();
    exp_q.push_back(24'd255);
    exp_q.push_back(24'd512);
    exp_q.push_back(24'd513);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      check("skip_seq", 32'(bus_def.slot_cnt), 32'(exp_q.pop_front()));
    end
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    check("abort1_done", 32'(bus_def.frame_done), 1);
    check("abort1_busy", 32'(bus_def.busy), 0);
    tick();
    check("idle1_done", 32'(bus_def.frame_done), 0);

    // Abort while idle has no effect.
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    check("idle_abort_done", 32'(bus_def.frame_done), 0);
    check("idle_abort_busy", 32'(bus_def.busy), 0);

    // ---- abort at 100 (stall raised together, abort wins) ----
    bus_def.start_en = 1'b1;
    tick();
    bus_def.start_en = 1'b0;
    for (int k = 1; k <= 100; k++) tick();
    check("pre_abort_slot", 32'(bus_def.slot_cnt), 100);
    bus_def.abort = 1'b1;
    bus_def.stall = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    bus_def.stall = 1'b0;
    check("abort_done", 32'(bus_def.frame_done), 1);
    check("abort_busy", 32'(bus_def.busy), 0);
    check("abort_en",   32'(en_def()), 0);
    // start_en held from the DONE cycle: ignored there, taken in IDLE.
    bus_def.start_en = 1'b1;
    tick();
    check("post_abort_done", 32'(bus_def.frame_done), 0);
    check("post_abort_busy", 32'(bus_def.busy), 0);
    tick();
    bus_def.start_en = 1'b0;
    check("restart_busy", 32'(bus_def.busy), 1);
    check("restart_slot", 32'(bus_def.slot_cnt), 0);
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    tick();

    // ---- no skip: 255 -> 256 ----
    bus_ns.start_en = 1'b1;
    tick();
    bus_ns.start_en = 1'b0;
    for (int k = 1; k <= 255; k++) tick();
    check("ns_255", 32'(bus_ns.slot_cnt), 255);
    tick();
    check("ns_256", 32'(bus_ns.slot_cnt), 256);
    bus_ns.abort = 1'b1;
    tick();
    bus_ns.abort = 1'b0;
    tick();

    // ---- short frame: natural end after count 39 ----
    // pop window [15,17): 16 is skipped so pop fires only after 15.
    // prefetch [33,35): both counts occur, two cycles.
    // out window [18,22) and mag_dir count 16 fall in the skipped line.
    bus_sm.start_en = 1'b1;
    tick();
    bus_sm.start_en = 1'b0;
    gn_cnt = 0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) tick();
      check("sm_slot", 32'(bus_sm.slot_cnt), 32'(exp_sm_slot(k)));
      check("sm_busy", 32'(bus_sm.busy), 32'(k <= 23));
      check("sm_done", 32'(bus_sm.frame_done), 32'(k == 24));
      check("sm_pop",  32'(bus_sm.pop_buffer_en), 32'(k == 16));
      check("sm_gn",   32'(bus_sm.get_next), 32'(k == 18 || k == 19));
      check("sm_md",   32'(bus_sm.mag_dir_en), 32'(k == 16));
      check("sm_out",  32'(bus_sm.out_en), 0);
      gn_cnt += int'(bus_sm.get_next);
    end
    check("sm_gn_cycles", 32'(gn_cnt), 2);
    // start_en only during DONE must be ignored.
    bus_sm.start_en = 1'b1;
    tick();
    bus_sm.start_en = 1'b0;
    check("sm_idle_busy", 32'(bus_sm.busy), 0);
    check("sm_idle_done", 32'(bus_sm.frame_done), 0);
    tick();
    check("sm_ignored_start", 32'(bus_sm.busy), 0);
    bus_sm.start_en = 1'b1;
    tick();
    bus_sm.start_en = 1'b0;
    check("sm_restart_busy", 32'(bus_sm.busy), 1);
    check("sm_restart_slot", 32'(bus_sm.slot_cnt), 0);
    tick();
    check("sm_restart_adv", 32'(bus_sm.slot_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
